// File: rtl/prf_multiport.sv
// Physical register file with per-register ready bits and a registered busy counter.
// Latency: reads are combinational with same-cycle write bypass; writes/allocs land at the next edge.
// Backpressure: none, every port is accepted every cycle.
//
// Ports:
//   clk, reset            : single clock, synchronous active-high reset
//   rd_addr/rd_data/rd_ready : NUM_RD read ports, tag in, data and ready out
//   wr_en/wr_addr/wr_data : NUM_WR writeback ports, set data and ready
//   alloc_en/alloc_addr   : NUM_ALLOC rename allocation ports, clear ready
//   busy_count            : registered number of registers whose ready bit is 0
module prf_multiport #(
  parameter int NUM_PREGS = 128,
  parameter int DATA_W    = 32,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 2,
  localparam int PREG_W   = $clog2(NUM_PREGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*PREG_W-1:0]    rd_addr,
  output logic [NUM_RD*DATA_W-1:0]    rd_data,
  output logic [NUM_RD-1:0]           rd_ready,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*PREG_W-1:0]    wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]    wr_data,
  input  logic [NUM_ALLOC-1:0]        alloc_en,
  input  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr,
  output logic [PREG_W:0]             busy_count
);

  logic [DATA_W-1:0]    data_q [NUM_PREGS];
  logic [DATA_W-1:0]    data_d [NUM_PREGS];
  logic [NUM_PREGS-1:0] ready_q;
  logic [NUM_PREGS-1:0] ready_d;
  logic [PREG_W:0]      busy_q;
  logic [PREG_W:0]      busy_d;

  // Next-state of the array. Writes are applied in ascending port order so the
  // highest port wins; allocations are applied afterwards so a same-cycle
  // allocation overrides the writeback's ready bit (it is the new producer).
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && (wr_addr[i*PREG_W +: PREG_W] != '0)) begin
        data_d[wr_addr[i*PREG_W +: PREG_W]]  = wr_data[i*DATA_W +: DATA_W];
        ready_d[wr_addr[i*PREG_W +: PREG_W]] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_ALLOC; j++) begin
      if (alloc_en[j] && (alloc_addr[j*PREG_W +: PREG_W] != '0)) begin
        ready_d[alloc_addr[j*PREG_W +: PREG_W]] = 1'b0;
      end
    end
    // Popcount of cleared ready bits; p0 is never cleared so it is skipped.
    busy_d = '0;
    for (int p = 1; p < NUM_PREGS; p++) begin
      busy_d = busy_d + {{PREG_W{1'b0}}, ~ready_d[p]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PREGS; p++) begin
        data_q[p] <= '0;
      end
      ready_q <= '1;
      busy_q  <= '0;
    end else begin
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Read ports: stored value, overridden by the winning same-cycle writeback,
  // and p0 forced to zero/ready regardless of anything else.
  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = data_q[rd_addr[k*PREG_W +: PREG_W]];
      rd_ready[k]                 = ready_q[rd_addr[k*PREG_W +: PREG_W]];
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i] && (wr_addr[i*PREG_W +: PREG_W] != '0) &&
            (wr_addr[i*PREG_W +: PREG_W] == rd_addr[k*PREG_W +: PREG_W])) begin
          rd_data[k*DATA_W +: DATA_W] = wr_data[i*DATA_W +: DATA_W];
          rd_ready[k]                 = 1'b1;
        end
      end
      if (rd_addr[k*PREG_W +: PREG_W] == '0) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_ready[k]                 = 1'b1;
      end
    end
  end

  assign busy_count = busy_q;

endmodule

// File: tb/tb_prf_multiport.sv
module tb_prf_multiport;
  localparam int NP  = 128;
  localparam int DW  = 32;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int NAL = 2;
  localparam int PW  = 7;

  logic               clk = 1'b0;
  logic               reset;
  logic [NRD*PW-1:0]  rd_addr;
  logic [NRD*DW-1:0]  rd_data;
  logic [NRD-1:0]     rd_ready;
  logic [NWR-1:0]     wr_en;
  logic [NWR*PW-1:0]  wr_addr;
  logic [NWR*DW-1:0]  wr_data;
  logic [NAL-1:0]     alloc_en;
  logic [NAL*PW-1:0]  alloc_addr;
  logic [PW:0]        busy_count;

  prf_multiport #(
    .NUM_PREGS(NP), .DATA_W(DW), .NUM_RD(NRD), .NUM_WR(NWR), .NUM_ALLOC(NAL)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference state: register contents plus the set of tags awaiting a producer.
  logic [DW-1:0] m_data [NP];
  bit            m_busy [int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void exp_read(input int tag, output logic [DW-1:0] d, output logic r);
    d = m_data[tag];
    r = !m_busy.exists(tag);
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i] && int'(wr_addr[i*PW +: PW]) == tag && tag != 0) begin
        d = wr_data[i*DW +: DW];
        r = 1'b1;
      end
    end
    if (tag == 0) begin
      d = '0;
      r = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      foreach (m_data[p]) m_data[p] = '0;
      m_busy.delete();
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && wr_addr[i*PW +: PW] != 0) begin
          m_data[int'(wr_addr[i*PW +: PW])] = wr_data[i*DW +: DW];
          m_busy.delete(int'(wr_addr[i*PW +: PW]));
        end
      end
      for (int j = 0; j < NAL; j++) begin
        if (alloc_en[j] && alloc_addr[j*PW +: PW] != 0)
          m_busy[int'(alloc_addr[j*PW +: PW])] = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    logic [DW-1:0] ed;
    logic          er;
    if (chk_en) begin
      check("busy_count", 64'(busy_count), 64'(m_busy.num()));
      if (!reset) begin
        for (int k = 0; k < NRD; k++) begin
          exp_read(int'(rd_addr[k*PW +: PW]), ed, er);
          check($sformatf("rd%0d_data", k), 64'(rd_data[k*DW +: DW]), 64'(ed));
          check($sformatf("rd%0d_ready", k), 64'(rd_ready[k]), 64'(er));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = '0; alloc_addr = '0; rd_addr = '0;
  endtask

  task automatic rd(input int k, input int tag);
    rd_addr[k*PW +: PW] = PW'(tag);
  endtask

  task automatic wr(input int i, input int tag, input logic [DW-1:0] d);
    wr_en[i] = 1'b1;
    wr_addr[i*PW +: PW] = PW'(tag);
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic al(input int j, input int tag);
    alloc_en[j] = 1'b1;
    alloc_addr[j*PW +: PW] = PW'(tag);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    // Reset for two cycles with writebacks that must be ignored.
    wr(0, 5, 32'hAAAA5555);
    wr(1, 6, 32'h5555AAAA);
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    rd(0, 5); rd(1, 6); rd(2, 127); rd(3, 0);
    sample();
    check("rst_p5_data", 64'(rd_data[31:0]), 64'h0);
    check("rst_p6_data", 64'(rd_data[63:32]), 64'h0);
    check("rst_p127_data", 64'(rd_data[95:64]), 64'h0);
    check("rst_ready", 64'(rd_ready), 64'hF);
    check("rst_busy", 64'(busy_count), 64'd0);

    // Allocate then write back p10.
    tick(); idle(); al(0, 10);
    tick(); idle(); rd(0, 10);
    sample();
    check("alloc_p10_ready", 64'(rd_ready[0]), 64'd0);
    check("alloc_p10_busy", 64'(busy_count), 64'd1);
    tick(); idle(); wr(0, 10, 32'hDEADBEEF); rd(0, 10);
    sample();
    check("byp_p10_data", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("byp_p10_ready", 64'(rd_ready[0]), 64'd1);
    tick(); idle(); rd(0, 10);
    sample();
    check("wb_p10_data", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("wb_p10_ready", 64'(rd_ready[0]), 64'd1);
    check("wb_p10_busy", 64'(busy_count), 64'd0);

    // p0 is immutable.
    tick(); idle(); wr(0, 0, 32'hFFFFFFFF); al(0, 0); rd(0, 0);
    sample();
    check("p0_same_data", 64'(rd_data[31:0]), 64'h0);
    check("p0_same_ready", 64'(rd_ready[0]), 64'd1);
    tick(); idle(); rd(0, 0);
    sample();
    check("p0_data", 64'(rd_data[31:0]), 64'h0);
    check("p0_busy", 64'(busy_count), 64'd0);

    // Same-tag conflicts.
    tick(); idle(); wr(0, 20, 32'd1); wr(1, 20, 32'd2); rd(1, 20);
    sample();
    check("ww_byp_p20", 64'(rd_data[63:32]), 64'd2);
    tick(); idle(); rd(0, 20);
    sample();
    check("ww_p20", 64'(rd_data[31:0]), 64'd2);
    tick(); idle(); al(0, 30); wr(0, 30, 32'd7); rd(0, 30);
    sample();
    check("aw_byp_ready", 64'(rd_ready[0]), 64'd1);
    tick(); idle(); rd(0, 30);
    sample();
    check("aw_p30_data", 64'(rd_data[31:0]), 64'd7);
    check("aw_p30_ready", 64'(rd_ready[0]), 64'd0);
    check("aw_busy", 64'(busy_count), 64'd1);
    tick(); idle(); al(0, 31); al(1, 31);
    tick(); idle();
    sample();
    check("aa_busy", 64'(busy_count), 64'd2);
    tick(); idle(); wr(0, 30, 32'd8); wr(1, 31, 32'd9);
    tick(); idle();
    sample();
    check("clear_busy", 64'(busy_count), 64'd0);

    // Fill every register, then write them all back, random reads throughout.
    for (int t = 1; t <= 127; t += 2) begin
      tick(); idle();
      al(0, t);
      if (t + 1 <= 127) al(1, t + 1);
      for (int k = 0; k < NRD; k++) rd(k, int'($urandom_range(127, 0)));
    end
    tick(); idle();
    sample();
    check("fill_busy", 64'(busy_count), 64'd127);
    for (int t = 1; t <= 127; t += 2) begin
      tick(); idle();
      wr(0, t, 32'h1000 + t);
      if (t + 1 <= 127) wr(1, t + 1, 32'h1000 + t + 1);
      for (int k = 0; k < NRD; k++) rd(k, int'($urandom_range(127, 0)));
    end
    tick(); idle(); rd(2, 77);
    sample();
    check("drain_busy", 64'(busy_count), 64'd0);
    check("drain_p77", 64'(rd_data[95:64]), 64'h104D);

    // Mid-run reset with 40 registers busy.
    for (int t = 1; t <= 40; t += 2) begin
      tick(); idle(); al(0, t); al(1, t + 1);
    end
    tick(); idle();
    sample();
    check("pre_rst_busy", 64'(busy_count), 64'd40);
    tick(); idle(); reset = 1'b1; wr(0, 50, 32'h12345678); al(0, 60);
    tick(); idle(); reset = 1'b0;
    rd(0, 5); rd(1, 40); rd(2, 50); rd(3, 60);
    sample();
    check("mrst_ready", 64'(rd_ready), 64'hF);
    check("mrst_p50", 64'(rd_data[95:64]), 64'h0);
    check("mrst_busy", 64'(busy_count), 64'd0);
    tick(); idle(); al(0, 3);
    tick(); idle(); rd(0, 3);
    sample();
    check("post_rst_ready", 64'(rd_ready[0]), 64'd0);
    check("post_rst_busy", 64'(busy_count), 64'd1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
